// File: rtl/sram_read_arbiter_if.sv
// Signal bundle between the two SRAM read requesters, the SRAM pins and the arbiter.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface sram_read_arbiter_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
);
   logic              REQ0;
   logic [ADDR_W-1:0] ADDR0;
   logic              GNT0;
   logic              RVALID0;
   logic [DATA_W-1:0] RDATA0;

   logic              REQ1;
   logic [ADDR_W-1:0] ADDR1;
   logic              GNT1;
   logic              RVALID1;
   logic [DATA_W-1:0] RDATA1;

   logic              BUSY;
   logic [ADDR_W-1:0] SRAM_A;
   logic [DATA_W-1:0] SRAM_D;
   logic              SRAM_WE;
   logic              SRAM_CE;
   logic              SRAM_OE;
   logic              SRAM_LB;
   logic              SRAM_UB;

   modport slave (
      input  REQ0, ADDR0, REQ1, ADDR1, SRAM_D,
      output GNT0, RVALID0, RDATA0, GNT1, RVALID1, RDATA1,
             BUSY, SRAM_A, SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB
   );

   modport master (
      output REQ0, ADDR0, REQ1, ADDR1, SRAM_D,
      input  GNT0, RVALID0, RDATA0, GNT1, RVALID1, RDATA1,
             BUSY, SRAM_A, SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB
   );
endinterface

// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter sharing one read-only SRAM port between two requesters.
// One read at a time: grant loads SRAM_A, data is captured READ_LAT edges later.
module sram_read_arbiter #(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 2
) (
   input logic                CLK,
   input logic                RST_N,
   sram_read_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(READ_LAT + 1);

   generate
      if (READ_LAT < 1) begin : g_bad_read_lat
         $error("sram_read_arbiter: READ_LAT must be >= 1");
      end
   endgenerate

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t            state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [ADDR_W-1:0] sram_a_q, sram_a_d;
   logic              owner_q,  owner_d;
   logic              last_q,   last_d;
   logic              gnt0_q,   gnt0_d;
   logic              gnt1_q,   gnt1_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              win;

   // Contention goes to the port that did not complete the previous read.
   assign win = (bus.REQ0 && bus.REQ1) ? ~last_q : bus.REQ1;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      sram_a_d  = sram_a_q;
      owner_d   = owner_q;
      last_d    = last_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.REQ0 || bus.REQ1) begin
               sram_a_d = win ? bus.ADDR1 : bus.ADDR0;
               gnt0_d   = ~win;
               gnt1_d   = win;
               owner_d  = win;
               cnt_d    = CNT_W'(READ_LAT - 1);
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               if (owner_q) begin
                  rdata1_d  = bus.SRAM_D;
                  rvalid1_d = 1'b1;
               end else begin
                  rdata0_d  = bus.SRAM_D;
                  rvalid0_d = 1'b1;
               end
               last_d  = owner_q;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sram_a_q  <= '0;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sram_a_q  <= sram_a_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign bus.GNT0    = gnt0_q;
   assign bus.GNT1    = gnt1_q;
   assign bus.RVALID0 = rvalid0_q;
   assign bus.RVALID1 = rvalid1_q;
   assign bus.RDATA0  = rdata0_q;
   assign bus.RDATA1  = rdata1_q;
   assign bus.BUSY    = (state_q != ST_IDLE);
   assign bus.SRAM_A  = sram_a_q;

   // Read-only, permanently selected device: pins are tied regardless of reset.
   assign bus.SRAM_WE = 1'b1;
   assign bus.SRAM_CE = 1'b0;
   assign bus.SRAM_OE = 1'b0;
   assign bus.SRAM_LB = 1'b0;
   assign bus.SRAM_UB = 1'b0;

endmodule
